// File: rtl/mesh_line_hop_pkg.sv
// Shared mesh definitions: flit layout, header field widths and the
// coordinate-compare routing helper used by every line-hop tile.
package mesh_line_hop_pkg;

  localparam int COORD_W   = 5;
  localparam int SZ_W      = 12;
  localparam int ADDR_W    = 33;
  localparam int HDR_W     = 2 * COORD_W + SZ_W + ADDR_W;
  localparam int PAYLOAD_W = 592;

  // Header sits in the low bits so its position does not move with payload width.
  typedef struct packed {
    logic [COORD_W-1:0] tx;
    logic [COORD_W-1:0] ty;
    logic [SZ_W-1:0]    sz;
    logic [ADDR_W-1:0]  addr;
  } hdr_t;

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    hdr_t                 hdr;
  } flit_t;

  typedef enum logic [1:0] {
    ROUTE_EJ,
    ROUTE_UP,
    ROUTE_DN
  } route_e;

  function automatic route_e route_of(input hdr_t hdr, input logic dim,
                                      input logic [COORD_W-1:0] here);
    logic [COORD_W-1:0] c;
    c = dim ? hdr.ty : hdr.tx;
    if (c == here)     return ROUTE_EJ;
    else if (c > here) return ROUTE_UP;
    else               return ROUTE_DN;
  endfunction

endpackage

// File: rtl/mesh_line_hop_fifo.sv
// In-order through-FIFO for one travel direction; pointers wrap modulo DEPTH.
module hop_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          rd_en, wr_en;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  assign head  = mem[rd_ptr];

  // NOTE: storage has no reset; emptiness is tracked by count alone.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mesh_line_hop.sv
// One tile of a 1-D mesh line: two through-FIFOs, credit-gated registered
// links in each direction, local injection and a round-robin ejection port.
module mesh_line_hop
  import mesh_line_hop_pkg::*;
#(
  parameter logic [COORD_W-1:0] TILE_X = '0,
  parameter logic [COORD_W-1:0] TILE_Y = '0,
  parameter int                 DIM    = 0,
  parameter int                 DW     = 592,
  parameter int                 DEPTH  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inj_valid,
  output logic                inj_ready,
  input  logic [DW+HDR_W-1:0] inj_flit,
  input  logic                dn_in_valid,
  input  logic [DW+HDR_W-1:0] dn_in_flit,
  input  logic                up_in_valid,
  input  logic [DW+HDR_W-1:0] up_in_flit,
  output logic                dn_in_crd,
  output logic                up_in_crd,
  output logic                up_out_valid,
  output logic [DW+HDR_W-1:0] up_out_flit,
  input  logic                up_out_crd,
  output logic                dn_out_valid,
  output logic [DW+HDR_W-1:0] dn_out_flit,
  input  logic                dn_out_crd,
  output logic                ej_valid,
  input  logic                ej_ready,
  output logic [DW+HDR_W-1:0] ej_flit,
  output logic                err
);
  localparam int                 FW      = DW + HDR_W;
  localparam int                 CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]      CRD_MAX = CW'(DEPTH);
  localparam logic               DIM_Y   = (DIM != 0);
  localparam logic [COORD_W-1:0] HERE    = DIM_Y ? TILE_Y : TILE_X;

  logic [FW-1:0] fu_head, fd_head;
  logic          fu_full, fu_empty, fu_pop, fu_push;
  logic          fd_full, fd_empty, fd_pop, fd_push;
  route_e        fu_route, fd_route, inj_route;
  logic          live;
  logic          fu_up_req, fu_ej_req, fd_dn_req, fd_ej_req;
  logic          inj_up_req, inj_dn_req, inj_ej_req;
  logic [CW-1:0] up_crd, dn_crd;
  logic          up_ok, dn_ok, up_pri_inj, dn_pri_inj;
  logic          up_inj_turn, dn_inj_turn, inj_ej_turn;
  logic          up_send_fu, up_send_inj, dn_send_fd, dn_send_inj;
  logic [1:0]    ej_ptr, ej_win;
  logic          ej_fire;

  // Winner index of a 3-way round-robin starting at ptr; 3 means no request.
  function automatic logic [1:0] rr3(input logic [2:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    rr3 = 2'd3;
    for (int k = 2; k >= 0; k--) begin
      idx = 2'((int'(ptr) + k) % 3);
      if (req[idx]) rr3 = idx;
    end
  endfunction

  function automatic logic [CW-1:0] crd_next(input logic [CW-1:0] c, input logic send,
                                             input logic ret);
    crd_next = c;
    if (ret && c != CRD_MAX) crd_next = crd_next + CW'(1);
    if (send)                crd_next = crd_next - CW'(1);
  endfunction

  assign fu_push = dn_in_valid & ~rst;
  assign fd_push = up_in_valid & ~rst;

  hop_fifo #(.DW(FW), .DEPTH(DEPTH)) u_fifo_u (
    .clk, .rst, .push(fu_push), .push_data(dn_in_flit), .pop(fu_pop),
    .head(fu_head), .full(fu_full), .empty(fu_empty)
  );

  hop_fifo #(.DW(FW), .DEPTH(DEPTH)) u_fifo_d (
    .clk, .rst, .push(fd_push), .push_data(up_in_flit), .pop(fd_pop),
    .head(fd_head), .full(fd_full), .empty(fd_empty)
  );

  // Requests are masked during reset so no handshake or credit escapes it.
  assign live       = ~rst;
  assign fu_route   = route_of(hdr_t'(fu_head[HDR_W-1:0]), DIM_Y, HERE);
  assign fd_route   = route_of(hdr_t'(fd_head[HDR_W-1:0]), DIM_Y, HERE);
  assign inj_route  = route_of(hdr_t'(inj_flit[HDR_W-1:0]), DIM_Y, HERE);
  assign fu_ej_req  = live & ~fu_empty & (fu_route == ROUTE_EJ);
  assign fu_up_req  = live & ~fu_empty & (fu_route != ROUTE_EJ);
  assign fd_ej_req  = live & ~fd_empty & (fd_route == ROUTE_EJ);
  assign fd_dn_req  = live & ~fd_empty & (fd_route != ROUTE_EJ);
  assign inj_ej_req = live & inj_valid & (inj_route == ROUTE_EJ);
  assign inj_up_req = live & inj_valid & (inj_route == ROUTE_UP);
  assign inj_dn_req = live & inj_valid & (inj_route == ROUTE_DN);

  assign up_ok       = (up_crd != '0);
  assign dn_ok       = (dn_crd != '0);
  assign up_inj_turn = ~fu_up_req | up_pri_inj;
  assign dn_inj_turn = ~fd_dn_req | dn_pri_inj;
  assign up_send_inj = inj_up_req & up_inj_turn & up_ok;
  assign up_send_fu  = fu_up_req & ~(inj_up_req & up_pri_inj) & up_ok;
  assign dn_send_inj = inj_dn_req & dn_inj_turn & dn_ok;
  assign dn_send_fd  = fd_dn_req & ~(inj_dn_req & dn_pri_inj) & dn_ok;

  assign ej_win      = rr3({inj_ej_req, fd_ej_req, fu_ej_req}, ej_ptr);
  assign inj_ej_turn = (rr3({1'b1, fd_ej_req, fu_ej_req}, ej_ptr) == 2'd2);
  assign ej_valid    = (ej_win != 2'd3);
  assign ej_fire     = ej_valid & ej_ready;

  assign fu_pop    = up_send_fu | (ej_fire & (ej_win == 2'd0));
  assign fd_pop    = dn_send_fd | (ej_fire & (ej_win == 2'd1));
  assign dn_in_crd = fu_pop;
  assign up_in_crd = fd_pop;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    ej_flit   = inj_flit;
    inj_ready = 1'b0;
    case (ej_win)
      2'd0:    ej_flit = fu_head;
      2'd1:    ej_flit = fd_head;
      default: ej_flit = inj_flit;
    endcase
    if (live) begin
      case (inj_route)
        ROUTE_UP: inj_ready = up_ok & up_inj_turn;
        ROUTE_DN: inj_ready = dn_ok & dn_inj_turn;
        default:  inj_ready = ej_ready & inj_ej_turn;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (up_send_fu | up_send_inj) up_out_flit <= up_send_inj ? inj_flit : fu_head;
    if (dn_send_fd | dn_send_inj) dn_out_flit <= dn_send_inj ? inj_flit : fd_head;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      up_out_valid <= 1'b0;
      dn_out_valid <= 1'b0;
      up_crd       <= CRD_MAX;
      dn_crd       <= CRD_MAX;
      up_pri_inj   <= 1'b0;
      dn_pri_inj   <= 1'b0;
      ej_ptr       <= 2'd0;
      err          <= 1'b0;
    end else begin
      up_out_valid <= up_send_fu | up_send_inj;
      dn_out_valid <= dn_send_fd | dn_send_inj;
      up_crd       <= crd_next(up_crd, up_send_fu | up_send_inj, up_out_crd);
      dn_crd       <= crd_next(dn_crd, dn_send_fd | dn_send_inj, dn_out_crd);
      if (up_send_fu | up_send_inj) up_pri_inj <= up_send_fu;
      if (dn_send_fd | dn_send_inj) dn_pri_inj <= dn_send_fd;
      if (ej_fire) ej_ptr <= (ej_win == 2'd2) ? 2'd0 : ej_win + 2'd1;
      if ((fu_push & fu_full & ~fu_pop) | (fd_push & fd_full & ~fd_pop) |
          (up_out_crd & (up_crd == CRD_MAX)) | (dn_out_crd & (dn_crd == CRD_MAX)))
        err <= 1'b1;
    end
  end

endmodule

// File: doc/mesh_line_hop.md
MESH_LINE_HOP -- requirements
Module: mesh_line_hop

Interface
REQ-001 Parameter TILE_X, default 0, this tile's X coordinate (5 bits).
REQ-002 Parameter TILE_Y, default 0, this tile's Y coordinate (5 bits).
REQ-003 Parameter DIM, default 0, selects the compared coordinate: 0 compares flit tx with TILE_X, 1 compares flit ty with TILE_Y.
REQ-004 Parameter DW, default 592, payload width.
REQ-005 Parameter DEPTH, default 8, entries per through-FIFO and initial credit count; power of two, 2..32.
REQ-006 clk  in  1  clock; all state updates on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 inj_valid / inj_ready / inj_flit  in / out / in  1 / 1 / FW  local injection port; a transfer occurs when inj_valid and inj_ready are both high.
REQ-009 dn_in_valid / dn_in_flit  in  1 / FW  flits from the lower-coordinate neighbour, travelling up.
REQ-010 up_in_valid / up_in_flit  in  1 / FW  flits from the higher-coordinate neighbour, travelling down.
REQ-011 dn_in_crd / up_in_crd  out  1  one-cycle credit-return pulses to the respective input neighbour.
REQ-012 up_out_valid / up_out_flit / up_out_crd  out / out / in  1 / FW / 1  link to the higher neighbour; up_out_crd is a credit pulse from that neighbour.
REQ-013 dn_out_valid / dn_out_flit / dn_out_crd  out / out / in  1 / FW / 1  link to the lower neighbour, same roles.
REQ-014 ej_valid / ej_ready / ej_flit  out / in / out  1 / 1 / FW  ejection port; a transfer occurs when ej_valid and ej_ready are both high.
REQ-015 err  out  1  sticky protocol-error flag.

Function
REQ-016 The flit is the package type: payload DW, tx 5, ty 5, sz 12, addr 33; the coordinate under test is tx when DIM=0 and ty when DIM=1.
REQ-017 A valid flit on dn_in is written to FIFO_U in the same cycle; a valid flit on up_in is written to FIFO_D.
REQ-018 Each FIFO head routes to ejection when its coordinate equals this tile's coordinate, otherwise it continues in its direction of travel.
REQ-019 An injected flit routes to ejection if its coordinate equals this tile's, to up if greater, and to down if less.
REQ-020 Each link output is a register; a flit leaves on a link only when that link's credit counter is nonzero, and the counter then decrements by 1.
REQ-021 Each link credit counter increments by 1 on its *_out_crd pulse; a send and a credit pulse in the same cycle leave the counter unchanged.
REQ-022 up link arbitration: when both the FIFO_U head and an up-bound injection request the link, they alternate round-robin, starting with the FIFO head after reset; the down link behaves the same.
REQ-023 The ejection arbiter is 3-way round-robin over FIFO_U, FIFO_D and injection, in that order from reset; ej_flit and ej_valid are combinational from the winning head.
REQ-024 inj_ready is high only when the injection flit's target (link credit and link grant, or ejection grant with ej_ready) accepts it in that cycle.
REQ-025 When a FIFO entry pops, the corresponding *_in_crd pulses for exactly one cycle.
REQ-026 Minimum latency: arrival at cycle t, link out valid at t+2; injection at t, link out valid at t+1; arrival at t, ej_valid at t+1.
REQ-027 Heads block in order (no bypass within a FIFO); FIFO read and write pointers wrap modulo DEPTH.
REQ-028 A write while both full and not popping, or a credit pulse at counter==DEPTH, sets err and drops the flit or credit; all other state is unaffected.
REQ-029 A simultaneous pop and write on a full FIFO is legal and keeps the occupancy at DEPTH.

Reset
REQ-030 On rst, both FIFOs are emptied, credit counters are set to DEPTH, round-robin pointers return to initial priority, and all valid, crd and err outputs are 0.
REQ-031 A reset asserted mid-operation discards all in-flight flits; no credit pulses are emitted for discarded entries.
REQ-032 ej_flit and link flit data are don't-care while the corresponding valid is low.

Structure
REQ-033 The flit typedef, the field widths and the coordinate-compare function shall live in the shared mesh package.
REQ-034 One sub-module, hop_fifo (parametrised DW, DEPTH, with full, empty and pop/push), shall be instantiated twice.

Verification
REQ-035 TILE_X=3, DIM=0: a dn_in flit with tx=3 gives ej_valid at t+1, and dn_in_crd pulses on the ej handshake.
REQ-036 A dn_in flit with tx=7 gives up_out_valid at t+2 with payload intact; up credit drops from 8 to 7.
REQ-037 With no up_out_crd returned, 9 up-bound flits produce exactly 8 sends; the 9th sends 1 cycle after an up_out_crd pulse.
REQ-038 With FIFO_U and injection continuously contending for up, the sends alternate FIFO, INJ, FIFO, INJ.
REQ-039 Writing dn_in while FIFO_U holds 8 entries and is stalled sets err to 1 and keeps occupancy at 8; rst clears err to 0 and the credits to 8.
